// File: rtl/fifo_reader.sv
// fifo_reader: pops a programmed number of words from a 16-bit FIFO through its
// rd/dout/valid/empty interface. Each word is forwarded to a downstream sink over
// a valid/ready handshake. The block counts accepted words and flags read errors.
module fifo_reader #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  output logic             fifo_rd,
  input  logic [WIDTH-1:0] fifo_dout,
  input  logic             fifo_valid,
  input  logic             fifo_empty,
  input  logic             fifo_under,
  output logic [WIDTH-1:0] m_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [LEN_W-1:0] word_cnt
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    WAIT  = 3'd2,
    OUT   = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [LEN_W-1:0]   r_rem;
  logic [LEN_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_data;
  logic               r_valid;
  logic               r_err;
  logic               w_rd_ok;
  logic               w_hs;

  assign w_rd_ok = fifo_valid && !fifo_under;
  assign w_hs    = r_valid && m_ready;

  // State register; reset abandons any read in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next;
  end

  // Next-state logic and combinational strobes.
  always_comb begin
    w_next  = r_state;
    fifo_rd = 1'b0;
    busy    = (r_state != IDLE);
    done    = (r_state == DONE);
    case (r_state)
      IDLE: begin
        if (start) w_next = (len == '0) ? DONE : ISSUE;
      end
      ISSUE: begin
        // Never strobe an empty FIFO; just wait here until data shows up.
        if (!fifo_empty) begin
          fifo_rd = 1'b1;
          w_next  = WAIT;
        end
      end
      WAIT: begin
        w_next = w_rd_ok ? OUT : ISSUE;
      end
      OUT: begin
        if (m_ready) w_next = (r_rem == LEN_W'(1)) ? DONE : ISSUE;
      end
      DONE: begin
        w_next = IDLE;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  // Datapath: remaining/accepted counters, output word register and sticky error.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rem   <= '0;
      r_cnt   <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_rem <= len;
            r_cnt <= '0;
            r_err <= 1'b0;
          end
        end
        WAIT: begin
          if (w_rd_ok) begin
            r_data  <= fifo_dout;
            r_valid <= 1'b1;
          end else begin
            r_err <= 1'b1;
          end
        end
        OUT: begin
          if (w_hs) begin
            r_valid <= 1'b0;
            r_cnt   <= r_cnt + 1'b1;
            r_rem   <= r_rem - 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign m_data   = r_data;
  assign m_valid  = r_valid;
  assign err      = r_err;
  assign word_cnt = r_cnt;

endmodule

// File: tb/tb_fifo_reader.sv
// Bench for fifo_reader: behavioural 1-cycle-latency FIFO, scoreboard of written
// words checked at the sink handshake, a table of transfer lengths and a set of
// hand-written corner-case sequences.
module tb_fifo_reader;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  len = '0;
  logic        fifo_rd;
  logic [15:0] fifo_dout = '0;
  logic        fifo_valid = 1'b0;
  logic        fifo_empty = 1'b1;
  logic        fifo_under = 1'b0;
  logic [15:0] m_data;
  logic        m_valid;
  logic        m_ready = 1'b1;
  logic        busy;
  logic        done;
  logic        err;
  logic [7:0]  word_cnt;

  logic        tb_wr = 1'b0;
  logic [15:0] tb_din = '0;
  logic        tb_force = 1'b0;

  logic [15:0] fq[$];
  logic [15:0] exp_q[$];

  int n_checks = 0;
  int n_err = 0;

  fifo_reader #(.WIDTH(16), .LEN_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .len(len),
    .fifo_rd(fifo_rd), .fifo_dout(fifo_dout), .fifo_valid(fifo_valid),
    .fifo_empty(fifo_empty), .fifo_under(fifo_under),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .busy(busy), .done(done), .err(err), .word_cnt(word_cnt)
  );

  always #5 clk = ~clk;

  // FIFO model; tb_force suppresses one read (no pop, valid stays low).
  always @(posedge clk) begin
    if (fifo_rd && fq.size() > 0 && !tb_force) begin
      fifo_dout  <= fq.pop_front();
      fifo_valid <= 1'b1;
      fifo_under <= 1'b0;
    end else if (fifo_rd && fq.size() == 0) begin
      fifo_valid <= 1'b0;
      fifo_under <= 1'b1;
    end else begin
      fifo_valid <= 1'b0;
      fifo_under <= 1'b0;
    end
    if (tb_wr) fq.push_back(tb_din);
    fifo_empty <= (fq.size() == 0);
  end

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  // Scoreboard: every sink handshake must deliver the oldest written word.
  always @(negedge clk) begin
    logic [15:0] e;
    if (rst && m_valid && m_ready) begin
      if (exp_q.size() == 0) begin
        check("sb_underrun", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("sb_data", m_data, e);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_word(input logic [15:0] w);
    tb_wr = 1'b1;
    tb_din = w;
    exp_q.push_back(w);
    tick();
    tb_wr = 1'b0;
  endtask

  // Steps from cycle c0 until done; optionally checks handshake k lands in cycle 3k.
  task automatic wait_done(input int c0, input int cmax, input bit chk_t,
                           output int done_c, output int rds);
    int hs = 0;
    done_c = -1;
    rds = 0;
    for (int c = c0; c <= cmax; c++) begin
      if (fifo_rd) rds++;
      if (m_valid && m_ready) begin
        hs++;
        if (chk_t) check("hs_cycle", c, 3 * hs);
      end
      if (done) begin
        done_c = c;
        break;
      end
      tick();
    end
  endtask

  task automatic run_xfer(input logic [7:0] l, input int exp_done, input int exp_cnt);
    int dc, rds;
    start = 1'b1;
    len = l;
    tick();
    start = 1'b0;
    wait_done(1, exp_done + 20, 1'b1, dc, rds);
    check("done_cycle", dc, exp_done);
    check("rd_pulses", rds, exp_cnt);
    tick();
    check("busy_after", busy, 0);
    check("word_cnt", word_cnt, exp_cnt);
    check("err_clean", err, 0);
    check("sb_drain", exp_q.size(), 0);
  endtask

  typedef struct {
    logic [7:0] len;
    int         exp_done;
    int         exp_cnt;
  } vec_t;

  vec_t vecs[6];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int dc, rds, vc;

    vecs[0] = '{len: 8'd1, exp_done: 4,  exp_cnt: 1};
    vecs[1] = '{len: 8'd2, exp_done: 7,  exp_cnt: 2};
    vecs[2] = '{len: 8'd5, exp_done: 16, exp_cnt: 5};
    vecs[3] = '{len: 8'd8, exp_done: 25, exp_cnt: 8};
    vecs[4] = '{len: 8'd0, exp_done: 1,  exp_cnt: 0};
    vecs[5] = '{len: 8'd4, exp_done: 13, exp_cnt: 4};

    // Reset state
    tick(); tick();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_rd", fifo_rd, 0);
    check("rst_mvalid", m_valid, 0);
    check("rst_mdata", m_data, 0);
    check("rst_err", err, 0);
    check("rst_cnt", word_cnt, 0);
    rst = 1'b1;
    tick();

    // Basic three-word transfer
    write_word(16'h1111);
    write_word(16'h2222);
    write_word(16'h3333);
    tick();
    run_xfer(8'd3, 10, 3);

    // Length table with random data
    for (int i = 0; i < 6; i++) begin
      for (int j = 0; j < int'(vecs[i].len); j++) write_word(16'($urandom_range(0, 16'hFFFF)));
      tick();
      run_xfer(vecs[i].len, vecs[i].exp_done, vecs[i].exp_cnt);
    end

    // Empty FIFO stalls ISSUE
    start = 1'b1; len = 8'd2; tick(); start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("empty_rd", fifo_rd, 0);
      check("empty_busy", busy, 1);
      if (i < 2) tick();
    end
    write_word(16'hABCD);
    rds = 0;
    for (int i = 0; i < 6; i++) begin
      if (fifo_rd) rds++;
      tick();
    end
    check("empty_one_rd", rds, 1);
    check("empty_busy2", busy, 1);
    check("empty_cnt1", word_cnt, 1);
    check("empty_rd_idle", fifo_rd, 0);
    write_word(16'h5678);
    wait_done(11, 40, 1'b0, dc, rds);
    check("empty_done", dc, 14);
    check("empty_rd2", rds, 1);
    tick();
    check("empty_cnt2", word_cnt, 2);

    // Sink back-pressure for five cycles
    m_ready = 1'b0;
    write_word(16'hBEEF);
    tick();
    start = 1'b1; len = 8'd1; tick(); start = 1'b0;
    vc = -1;
    for (int c = 1; c <= 10; c++) begin
      if (m_valid) begin vc = c; break; end
      tick();
    end
    check("stall_vrise", vc, 3);
    for (int i = 0; i < 5; i++) begin
      check("stall_data", m_data, 16'hBEEF);
      check("stall_valid", m_valid, 1);
      check("stall_rd", fifo_rd, 0);
      tick();
    end
    m_ready = 1'b1;
    check("stall_hs_valid", m_valid, 1);
    tick();
    check("stall_done", done, 1);
    check("stall_vfall", m_valid, 0);
    tick();
    check("stall_cnt", word_cnt, 1);
    check("stall_busy", busy, 0);

    // Failed read in first WAIT: retry and sticky err
    write_word(16'hA5A5);
    write_word(16'h5A5A);
    tick();
    start = 1'b1; len = 8'd2; tick(); start = 1'b0;
    tb_force = 1'b1;
    check("err_rd1", fifo_rd, 1);
    tick();
    tb_force = 1'b0;
    check("err_pre", err, 0);
    tick();
    check("err_set", err, 1);
    check("err_reissue", fifo_rd, 1);
    wait_done(3, 40, 1'b0, dc, rds);
    check("err_done", dc, 9);
    check("err_rds", rds, 2);
    tick();
    check("err_cnt", word_cnt, 2);
    check("err_sticky", err, 1);
    start = 1'b1; len = 8'd0; tick(); start = 1'b0;
    check("len0_done", done, 1);
    check("len0_errclr", err, 0);
    check("len0_rd", fifo_rd, 0);
    tick();
    check("len0_busy", busy, 0);
    check("len0_cnt", word_cnt, 0);

    // start while busy is ignored
    write_word(16'h0F0F);
    write_word(16'hF0F0);
    tick();
    start = 1'b1; len = 8'd2; tick(); start = 1'b0;
    tick();
    start = 1'b1; len = 8'd5; tick(); start = 1'b0; len = 8'd0;
    wait_done(3, 40, 1'b0, dc, rds);
    check("ign_done", dc, 7);
    tick();
    check("ign_cnt", word_cnt, 2);
    check("ign_busy", busy, 0);

    // Asynchronous reset while holding a word in OUT
    m_ready = 1'b0;
    write_word(16'h1357);
    tick();
    start = 1'b1; len = 8'd1; tick(); start = 1'b0;
    vc = -1;
    for (int c = 1; c <= 10; c++) begin
      if (m_valid) begin vc = c; break; end
      tick();
    end
    check("rst_pre_valid", vc, 3);
    rst = 1'b0;
    #1;
    check("arst_mvalid", m_valid, 0);
    check("arst_busy", busy, 0);
    check("arst_rd", fifo_rd, 0);
    check("arst_cnt", word_cnt, 0);
    check("arst_mdata", m_data, 0);
    exp_q.delete();
    tick();
    rst = 1'b1;
    m_ready = 1'b1;
    tick();
    write_word(16'h2468);
    tick();
    run_xfer(8'd1, 4, 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
